inst_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the instruction RAM's write port.
- Accepts a byte stream (UART/DMA side) over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives is_write/im_addr/im_inst, one word-aligned write per assembled word.
- Holds the core in stall until the image is complete, then pulses done.

---
 rtl/pesurv_pkg.sv | 17 +
 rtl/inst_loader_byte_packer.sv | 33 +++
 rtl/inst_loader.sv | 151 +++++++++++++++
 tb/tb_inst_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pesurv_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package pesurv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_INC       = BYTES_PER_WORD;
  localparam int unsigned ADDR_SHIFT     = $clog2(ADDR_INC);

endpackage

// File: rtl/inst_loader_byte_packer.sv
// 8->32 little-endian assembler; o_word_c/o_word_valid_c are valid in the cycle of the 4th byte handshake.
module byte_packer
  import pesurv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_fire,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_c,
  output logic        o_word_valid_c
);

  localparam int unsigned CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] r_cnt;
  logic [23:0]   r_shift;

  // Only the first three bytes are stored; the fourth completes the word combinationally.
  assign o_word_c       = {i_byte, r_shift};
  assign o_word_valid_c = i_fire && (r_cnt == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_fire) begin
      r_cnt   <= r_cnt + CW'(1);
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader feeding the instruction RAM write port.
// Optional trailing checksum word enabled by INST_LOADER_CSUM_EN.
module inst_loader
  import pesurv_pkg::*;
#(
  parameter int unsigned   W         = 32,
  parameter logic [W-1:0]  BASE_ADDR = '0,
  parameter int unsigned   MAX_WORDS = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         is_write,
  output logic [W-1:0] im_addr,
  output logic [W-1:0] im_inst,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  localparam int unsigned IDXW = $clog2(MAX_WORDS + 1);

  state_t          r_state;
  logic [31:0]     r_len;
  logic [IDXW-1:0] r_idx;
`ifdef INST_LOADER_CSUM_EN
  logic [31:0]     r_sum;
`endif

  logic        w_fire;
  logic        w_start_ok;
  logic        w_last_word;
  logic [31:0] w_word;
  logic        w_word_valid;

  assign w_fire      = in_valid && in_ready;
  assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
  assign w_last_word = (32'(r_idx) == (r_len - 32'd1));

  byte_packer u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (w_start_ok),
    .i_fire         (w_fire),
    .i_byte         (in_byte),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
`ifdef INST_LOADER_CSUM_EN
      r_sum     <= '0;
`endif
      in_ready  <= 1'b0;
      is_write  <= 1'b0;
      im_addr   <= BASE_ADDR;
      im_inst   <= '0;
      core_hold <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      is_write <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start_ok) begin
            r_state   <= ST_LEN;
            r_idx     <= '0;
`ifdef INST_LOADER_CSUM_EN
            r_sum     <= '0;
`endif
            in_ready  <= 1'b1;
            core_hold <= 1'b1;
            err       <= 1'b0;
          end
        end
        ST_LEN: begin
          if (w_word_valid) begin
            r_len <= w_word;
            r_idx <= '0;
            if (w_word == 32'd0) begin
`ifdef INST_LOADER_CSUM_EN
              r_state   <= ST_CSUM;
`else
              r_state   <= ST_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
              in_ready  <= 1'b0;
`endif
            end else if (w_word > 32'(MAX_WORDS)) begin
              r_state   <= ST_ERR;
              err       <= 1'b1;
              core_hold <= 1'b0;
              in_ready  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            is_write <= 1'b1;
            im_inst  <= W'(w_word);
            im_addr  <= BASE_ADDR + (W'(r_idx) << ADDR_SHIFT);
            r_idx    <= r_idx + IDXW'(1);
`ifdef INST_LOADER_CSUM_EN
            r_sum    <= r_sum + w_word;
            if (w_last_word) r_state <= ST_CSUM;
`else
            // Last word: drop in_ready in the write cycle so no trailing byte is taken.
            if (w_last_word) begin
              r_state   <= ST_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
              in_ready  <= 1'b0;
            end
`endif
          end
        end
`ifdef INST_LOADER_CSUM_EN
        ST_CSUM: begin
          if (w_word_valid) begin
            core_hold <= 1'b0;
            in_ready  <= 1'b0;
            if (w_word == r_sum) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              err     <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b0;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed sequence with random data words and stalls.
module tb_inst_loader;

  localparam int unsigned  W         = 32;
  localparam logic [31:0]  BASE      = 32'h0000_1000;
  localparam int unsigned  MAXW      = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic         is_write;
  logic [W-1:0] im_addr;
  logic [W-1:0] im_inst;
  logic         core_hold;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_done = 0;
  logic [31:0] g_words[$];

  inst_loader #(.W(W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_write  (is_write),
    .im_addr   (im_addr),
    .im_inst   (im_inst),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every strobe so duplicated or missing writes/done pulses are caught.
  always @(negedge clk) begin
    if (is_write === 1'b1) n_wr <= n_wr + 1;
    if (done === 1'b1) n_done <= n_done + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // stall: 0 none, 1 one idle cycle before each byte, 2 random idle cycles.
  task automatic send_byte(input logic [7:0] b, input int stall);
    bit hs;
    int guard;
    int idle;
    hs = 1'b0;
    guard = 0;
    idle = (stall == 1) ? 1 : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (idle) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      step();
    end
    while (!hs && guard < 20) begin
      in_valid = 1'b1;
      in_byte  = b;
      hs = in_ready;
      step();
      guard++;
    end
    if (!hs) chk("hs_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      send_byte(b, stall);
    end
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Reference: word i lands at BASE+4i; len 0 or in range completes, over MAXW errors.
  task automatic run_load(input logic [31:0] len, input int stall, input logic [31:0] csum_delta,
                          input bit mid_start);
    int          wr0;
    int          dn0;
    logic [31:0] sum;
    logic [31:0] w;
    bit          ok;
    bit          exp_ok;
    wr0 = n_wr;
    dn0 = n_done;
    sum = 32'd0;
    ok  = (len <= MAXW);
    pulse_start();
    chk("hold_on_start", 32'(core_hold), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    send_word(len, stall);
    if (ok) begin
      for (int i = 0; i < int'(len); i++) begin
        w = (i < g_words.size()) ? g_words[i] : $urandom;
        send_word(w, stall);
        chk("wr_strobe", 32'(is_write), 32'd1);
        chk("wr_addr", im_addr, BASE + 32'(4 * i));
        chk("wr_data", im_inst, w);
        sum += w;
        if (mid_start && i == 0) pulse_start();
      end
`ifdef INST_LOADER_CSUM_EN
      send_word(sum + csum_delta, stall);
`endif
    end
    in_valid = 1'b0;
    repeat (3) step();
`ifdef INST_LOADER_CSUM_EN
    exp_ok = ok && (csum_delta == 32'd0);
`else
    exp_ok = ok;
`endif
    chk("write_count", 32'(n_wr - wr0), ok ? len : 32'd0);
    chk("done_count", 32'(n_done - dn0), exp_ok ? 32'd1 : 32'd0);
    chk("err_flag", 32'(err), exp_ok ? 32'd0 : 32'd1);
    chk("hold_after", 32'(core_hold), 32'd0);
    chk("ready_after", 32'(in_ready), 32'd0);
  endtask

  initial begin
    int wr0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_write", 32'(is_write), 32'd0);
    chk("rst_addr", im_addr, BASE);
    chk("rst_inst", im_inst, 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_nowrites", 32'(n_wr), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();

    // Basic image, then the same image with a stalled stream.
    g_words = '{32'hDEAD_BEEF, 32'h0000_0013};
    run_load(32'd2, 0, 32'd0, 1'b0);
    run_load(32'd2, 1, 32'd0, 1'b0);

    // Zero length, oversize length, then recovery with random words at the size limit.
    g_words = {};
    run_load(32'd0, 0, 32'd0, 1'b0);
    run_load(32'(MAXW + 1), 0, 32'd0, 1'b0);
    run_load(32'(MAXW), 2, 32'd0, 1'b0);
    run_load(32'd3, 2, 32'd0, 1'b0);

    // Start pulse during DATA is ignored.
    run_load(32'd3, 0, 32'd0, 1'b1);

    // Reset after 1.5 words: only word 0 written, then a clean reload.
    wr0 = n_wr;
    pulse_start();
    send_word(32'd4, 0);
    send_word(32'h1122_3344, 0);
    chk("mid_wr_data", im_inst, 32'h1122_3344);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst_n = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    chk("mid_rst_writes", 32'(n_wr - wr0), 32'd1);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_hold", 32'(core_hold), 32'd0);
    chk("mid_rst_inst", im_inst, 32'd0);
    rst_n = 1'b1;
    step();
    run_load(32'd2, 0, 32'd0, 1'b0);

`ifdef INST_LOADER_CSUM_EN
    g_words = '{32'h1, 32'h2};
    run_load(32'd2, 0, 32'd0, 1'b0);
    run_load(32'd2, 0, 32'd1, 1'b0);
    g_words = {};
    run_load(32'd0, 0, 32'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
